// File: rtl/uart_tx_framer.sv
// uart_tx_framer -- parallel-to-serial UART transmit framer.
//
// Sends one frame per accepted request: start bit (0), DATA_WIDTH data bits
// LSB first, an optional parity bit, and one stop bit (1). Each bit lasts
// Prescale clk cycles; only Prescale values 8, 16 and 32 are accepted.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   Prescale   in   clk cycles per UART bit (8/16/32)
//   P_DATA     in   parallel payload
//   Data_Valid in   one-cycle send request
//   PAR_EN     in   1 = append parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   TX_OUT     out  serial line, idle high, registered
//   Busy       out  frame in progress, registered
module uart_tx_framer #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            Prescale,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [4:0]            edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [5:0]            prescale_q;

   logic                  prescale_ok;
   logic                  edge_wrap;
   logic                  last_bit;
   logic                  parity_bit;
   logic [BW-1:0]         bit_nxt;

   always_comb begin
      prescale_ok = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
      // Latched prescale of 32 still fits: the counter tops out at 31.
      edge_wrap   = ({1'b0, edge_cnt} == (prescale_q - 6'd1));
      last_bit    = (bit_cnt == BW'(DATA_WIDTH - 1));
      bit_nxt     = bit_cnt + BW'(1);
      parity_bit  = (^data_q) ^ par_typ_q;
   end

   // TX_OUT is loaded with the value of the next bit on the same edge that
   // changes state, so the line is registered with no extra latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         TX_OUT     <= 1'b1;
         Busy       <= 1'b0;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         prescale_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               TX_OUT   <= 1'b1;
               Busy     <= 1'b0;
               edge_cnt <= '0;
               bit_cnt  <= '0;
               if (Data_Valid && !Busy && prescale_ok) begin
                  data_q     <= P_DATA;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
                  prescale_q <= Prescale;
                  TX_OUT     <= 1'b0;
                  Busy       <= 1'b1;
                  state      <= START;
               end
            end

            START: begin
               if (edge_wrap) begin
                  edge_cnt <= '0;
                  TX_OUT   <= data_q[0];
                  state    <= DATA;
               end else begin
                  edge_cnt <= edge_cnt + 5'd1;
               end
            end

            DATA: begin
               if (edge_wrap) begin
                  edge_cnt <= '0;
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        TX_OUT <= parity_bit;
                        state  <= PARITY;
                     end else begin
                        TX_OUT <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_nxt;
                     TX_OUT  <= data_q[bit_nxt];
                  end
               end else begin
                  edge_cnt <= edge_cnt + 5'd1;
               end
            end

            PARITY: begin
               if (edge_wrap) begin
                  edge_cnt <= '0;
                  TX_OUT   <= 1'b1;
                  state    <= STOP;
               end else begin
                  edge_cnt <= edge_cnt + 5'd1;
               end
            end

            STOP: begin
               if (edge_wrap) begin
                  edge_cnt <= '0;
                  TX_OUT   <= 1'b1;
                  Busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  edge_cnt <= edge_cnt + 5'd1;
               end
            end

            default: begin
               state    <= IDLE;
               TX_OUT   <= 1'b1;
               Busy     <= 1'b0;
               edge_cnt <= '0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer -- self-checking bench for uart_tx_framer.
//
// Stimulus pushes the hand-computed frame (bits in transmit order, bit
// period, required idle gap before it) into a queue; a monitor captures
// TX_OUT for every cycle Busy is high and checks each completed frame
// against the head of the queue.
module tb_uart_tx_framer;

   logic       clk;
   logic       rst;
   logic [5:0] Prescale;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   uart_tx_framer #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .Prescale   (Prescale),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // seq[nbits-1] is the first bit on the line (start bit).
   typedef struct {
      int          nbits;
      logic [11:0] seq;
      int          presc;
      int          gap;    // required idle cycles before the frame, -1 = any
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // ---------------- monitor ----------------
   logic trace [0:1023];
   int   cyc       = 0;
   int   idle_cnt  = 0;
   int   cur_gap   = -1;
   bit   in_frame  = 1'b0;
   bit   have_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         in_frame  = 1'b0;
         have_prev = 1'b0;
         idle_cnt  = 0;
      end else if (Busy) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            cyc      = 0;
            cur_gap  = have_prev ? idle_cnt : -1;
         end
         if (cyc < 1024) trace[cyc] = TX_OUT;
         cyc++;
      end else begin
         n_checks++;
         if (TX_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_line: TX_OUT=%b required 1 at %0t", TX_OUT, $time);
         end
         if (in_frame) begin
            in_frame  = 1'b0;
            have_prev = 1'b1;
            idle_cnt  = 1;
            check_frame();
         end else begin
            idle_cnt++;
         end
      end
   end

   task automatic check_frame();
      exp_t e;
      int   bad;
      int   lim;
      logic eb;
      logic bad_exp;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_frame: %0d-cycle frame seen, required none at %0t", cyc, $time);
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (cyc != e.nbits * e.presc) begin
            n_fail++;
            $display("FAIL frame_len: %0d cycles, required %0d at %0t", cyc, e.nbits * e.presc, $time);
         end
         lim = e.nbits * e.presc;
         if (cyc < lim) lim = cyc;
         if (lim > 1024) lim = 1024;
         bad     = -1;
         bad_exp = 1'b0;
         for (int c = 0; c < lim; c++) begin
            eb = e.seq[e.nbits - 1 - c / e.presc];
            if (bad < 0 && trace[c] !== eb) begin
               bad     = c;
               bad_exp = eb;
            end
         end
         n_checks++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL frame_bits: cycle %0d TX_OUT=%b required %b at %0t", bad, trace[bad], bad_exp, $time);
         end
         if (e.gap >= 0) begin
            n_checks++;
            if (cur_gap != e.gap) begin
               n_fail++;
               $display("FAIL frame_gap: %0d idle cycles, required %0d at %0t", cur_gap, e.gap, $time);
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic push_exp(input int nbits, input logic [11:0] seq, input int presc, input int gap);
      exp_t e;
      e.nbits = nbits;
      e.seq   = seq;
      e.presc = presc;
      e.gap   = gap;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt);
      @(posedge clk); #1;
      P_DATA     = d;
      Prescale   = ps;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      @(posedge clk); #1;
      Data_Valid = 1'b0;
   endtask

   task automatic wait_busy(input logic val, input int max_cyc, input string what);
      int k;
      k = 0;
      while (Busy !== val && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (Busy !== val) begin
         n_fail++;
         $display("FAIL %s: Busy=%b, required %b within %0d cycles", what, Busy, val, max_cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit bad;
      rst        = 1'b0;
      Prescale   = 6'd8;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      #23;
      n_checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: TX_OUT=%b Busy=%b, required 1 0", TX_OUT, Busy);
      end
      @(negedge clk); #1 rst = 1'b1;

      // 0xA5, no parity, 8 cycles/bit: 80-cycle frame
      push_exp(10, 12'b0101001011, 8, -1);
      send(8'hA5, 6'd8, 1'b0, 1'b0);
      wait_busy(1'b1, 5, "a5_start");
      wait_busy(1'b0, 200, "a5_end");

      // 0x01 with even parity (bit 1); PAR_TYP flipped after acceptance
      push_exp(11, 12'b01000000011, 16, -1);
      send(8'h01, 6'd16, 1'b1, 1'b0);
      wait_busy(1'b1, 5, "even_start");
      PAR_TYP = 1'b1;
      wait_busy(1'b0, 300, "even_end");

      // 0x01 with odd parity (bit 0)
      push_exp(11, 12'b01000000001, 16, -1);
      send(8'h01, 6'd16, 1'b1, 1'b1);
      wait_busy(1'b1, 5, "odd_start");
      PAR_TYP = 1'b0;
      wait_busy(1'b0, 300, "odd_end");

      // 0x5A at 8 cycles/bit, Prescale changed to 32 during data bit 2
      push_exp(10, 12'b0010110101, 8, -1);
      send(8'h5A, 6'd8, 1'b0, 1'b0);
      wait_busy(1'b1, 5, "presc_start");
      repeat (28) @(negedge clk);
      Prescale = 6'd32;
      wait_busy(1'b0, 200, "presc_end");

      // Data_Valid held high at 32 cycles/bit: 0x3C latched, then 0xC3
      // accepted in the single idle cycle after the first frame.
      push_exp(10, 12'b0001111001, 32, -1);
      push_exp(10, 12'b0110000111, 32, 1);
      @(posedge clk); #1;
      Prescale   = 6'd32;
      PAR_EN     = 1'b0;
      P_DATA     = 8'h3C;
      Data_Valid = 1'b1;
      wait_busy(1'b1, 5, "b2b_first_start");
      repeat (100) @(negedge clk);
      P_DATA = 8'hC3;
      wait_busy(1'b0, 400, "b2b_first_end");
      wait_busy(1'b1, 5, "b2b_second_start");
      repeat (100) @(negedge clk);
      Data_Valid = 1'b0;
      wait_busy(1'b0, 400, "b2b_second_end");
      bad = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (Busy !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL no_queue: Busy rose after hold released, required 0");
      end

      // reset asserted during data bit 4 of a 0x00 frame
      send(8'h00, 6'd8, 1'b0, 1'b0);
      wait_busy(1'b1, 5, "rst_frame_start");
      repeat (43) @(negedge clk);
      n_checks++;
      if (TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_bit: TX_OUT=%b, required 0", TX_OUT);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: TX_OUT=%b Busy=%b, required 1 0", TX_OUT, Busy);
      end
      repeat (3) @(negedge clk);
      push_exp(10, 12'b0001111001, 16, -1);
      #1;
      rst        = 1'b1;
      P_DATA     = 8'h3C;
      Prescale   = 6'd16;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      @(posedge clk); #1;
      Data_Valid = 1'b0;
      n_checks++;
      if (Busy !== 1'b1 || TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL first_edge_accept: Busy=%b TX_OUT=%b, required 1 0", Busy, TX_OUT);
      end
      wait_busy(1'b0, 300, "post_reset_end");

      // illegal Prescale: request dropped
      send(8'hFF, 6'd12, 1'b0, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (Busy !== 1'b0 || TX_OUT !== 1'b1) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL bad_prescale: Busy/TX_OUT left idle, required Busy=0 TX_OUT=1");
      end

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL frames_missing: %0d expected frames unseen, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
